money_scan_disp: RTL and testbench
==================================

Name: money_scan_disp

Overview:
- Parametrised successor to the vending-machine money display.
- Converts a binary half-unit money value to BCD with a sequential double-dabble sub-block, then time-multiplexes a common-anode 7-segment bank. Segments and digit selects are active-low.
- Adds, relative to the fixed 4-digit version: configurable integer-digit count, leading-zero blanking, overflow indication, scan prescaler, blanking input and parametrised label positions.
- Sits between the vending controller's money register and the board display pins.

Parameters:
- VAL_W, 8, width of moneyv; LSB is the 0.5 unit, bits [VAL_W-1:1] are the integer part.
- NUM_DIG, 8, total digit positions driven (width of sdpsel).
- INT_DIG, 3, integer digits shown; requires INT_DIG+1 <= NUM_DIG.
- SCAN_DIV, 1, clk cycles each digit stays selected (>=1).
- BLANK_LZ, 1, 1 = blank leading zeros above the ones digit.
- LABEL, {8{8'hFF}}, 8*NUM_DIG bits; byte k is the segment pattern for position k when k > INT_DIG.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- moneyv  input  VAL_W  money value in half units.
- blank  input  1  1 = all digits deselected (sdpsel all ones); scanning continues.
- sdpsel  output  NUM_DIG  one-cold digit select.
- sdpdisp  output  8  segment pattern; bit7 = DP, bits6:0 = g..a, active-low.
- ovf  output  1  integer part of the committed value needs more than INT_DIG digits.
- upd  output  1  one-cycle pulse when a new conversion is committed to the display register.

Behaviour:
- Reset (async assert, sync release): sdpsel=all 1, sdpdisp=8'hFF, ovf=0, upd=0, digit index=0, prescaler=0, display BCD=0, half bit=0, converter IDLE.
- Converter FSM (money_bin2bcd):
  - IDLE: samples moneyv[VAL_W-1:1] and moneyv[0] and goes to SHIFT next cycle. Sampling is free-running, so the FSM restarts immediately after each DONE.
  - SHIFT: VAL_W-1 cycles of add-3-if-≥5 on each BCD nibble, then shift left one bit.
  - DONE: one cycle; commits BCD (NBCD nibbles), half bit and ovf to the display register atomically and pulses upd.
  - Sample-to-commit latency is VAL_W+1 cycles (9 at default).
  - moneyv changes during SHIFT are ignored until the next IDLE sample.
- NBCD = decimal digits needed for 2^(VAL_W-1)-1. ovf=1 when any nibble at index >= INT_DIG is nonzero.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the index advances 0..NUM_DIG-1 and wraps to 0.
  - sdpsel and sdpdisp are registered: one cycle after the index changes, they reflect the new index.
  - Only one select bit is low at a time.
- Pattern per position k, when ovf=0:
  - k=0: half digit, '5' (8'h92) if the half bit is set, else '0' (8'hC0).
  - k=1: ones digit with DP lit (bit7=0).
  - 2..INT_DIG: BCD nibble k-1. With BLANK_LZ=1, the position shows 8'hFF when the nibble and all higher integer nibbles are zero. The ones digit is never blanked.
  - k>INT_DIG: LABEL byte k.
- With ovf=1, positions 0..INT_DIG show dash 8'hBF (position 1 shows 8'h3F, dash plus DP); labels are unchanged.
- blank=1 forces sdpsel all ones on the next registered cycle; sdpdisp continues to update.
- Mid-operation reset: outputs return to reset values asynchronously. After release, the first upd occurs VAL_W+2 cycles later.
- All digit arithmetic is unsigned; nibbles are never ≥10 after conversion.

Decomposition:
- Package money_disp_pkg:
  - SEG_BLANK (8'hFF), SEG_DASH (8'hBF), DP_MASK.
  - Constant array SEG_DIGIT[0:9] (8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90).
  - Function nbcd(VAL_W).
- Sub-module money_bin2bcd: IDLE/SHIFT/DONE FSM, parameter VAL_W, outputs bcd, half, done.
- Top holds the prescaler, index counter, display register and pattern mux.

Test Plan:
- Default params, moneyv=245 (122.5), wait 10 cycles, scan one frame -> positions 0..3 = 8'h92, 8'h24, 8'hA4, 8'hF9; ovf=0; one upd pulse per conversion.
- moneyv=7 (3.5), BLANK_LZ=1 -> position0=8'h92, position1=8'h30, positions 2,3 = 8'hFF. With BLANK_LZ=0, positions 2,3 = 8'hC0.
- INT_DIG=2, moneyv=245 -> ovf=1; positions 0,2 = 8'hBF, position1 = 8'h3F; positions ≥3 = LABEL bytes.
- SCAN_DIV=4 -> sdpsel holds 8'b11111110 for exactly 4 cycles, then 8'b11111101; after 32 cycles it returns to 8'b11111110.
- Assert rst_n=0 mid-SHIFT and mid-scan -> sdpsel=8'hFF and sdpdisp=8'hFF immediately; after release, index restarts at 0 and the first upd arrives 10 cycles later.
- blank=1 for 5 cycles -> sdpsel=8'hFF during that window, index still advances; scan resumes at the correct position after blank=0.

Source files
------------

// File: rtl/money_disp_pkg.sv
// Shared constants and helpers for the money display: segment encodings,
// BCD digit-count helper and the converter state type.
package money_disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] DP_MASK   = 8'h7F;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Decimal digits needed to show the largest integer part, 2^(val_w-1)-1.
    function automatic int nbcd(input int val_w);
        longint m;
        int     n;
        m = (longint'(1) << (val_w - 1)) - 1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (m >= 10) begin
                m = m / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        return (d < 4'd10) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/money_scan_disp_bin2bcd.sv
// Sequential double-dabble converter for the integer part of the money value.
// Free-running: samples in IDLE, shifts VAL_W-1 times, flags DONE for one cycle.
module money_bin2bcd
    import money_disp_pkg::*;
#(
    parameter int VAL_W = 8,
    parameter int NBCD  = nbcd(VAL_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      i_val,
    output logic [4*NBCD-1:0]     o_bcd,
    output logic                  o_half,
    output logic                  o_done
);

    localparam int IW = VAL_W - 1;
    localparam int CW = (VAL_W > 2) ? $clog2(VAL_W) : 1;

    conv_state_e         r_state;
    conv_state_e         w_next;
    logic [IW-1:0]       r_bin;
    logic [4*NBCD-1:0]   r_bcd;
    logic [4*NBCD-1:0]   w_adj;
    logic                r_half;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    logic                w_load;
    logic                w_shift;
    logic                w_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load  = (r_state == ST_IDLE);
        w_shift = (r_state == ST_SHIFT);
        w_fin   = (r_state == ST_DONE);
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NBCD; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_half <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_bin  <= i_val[VAL_W-1:1];
                r_half <= i_val[0];
                r_bcd  <= '0;
                r_cnt  <= CW'(VAL_W - 2);
            end else if (w_shift) begin
                // Top BCD bit is always zero here, so dropping it is lossless.
                {r_bcd, r_bin} <= {w_adj[4*NBCD-2:0], r_bin, 1'b0};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_half = r_half;
    assign o_done = r_done;

endmodule

// File: rtl/money_scan_disp.sv
// Multiplexed common-anode 7-segment money display: BCD conversion, display
// register with overflow flag, scan prescaler/index and per-position pattern mux.
module money_scan_disp
    import money_disp_pkg::*;
#(
    parameter int                     VAL_W    = 8,
    parameter int                     NUM_DIG  = 8,
    parameter int                     INT_DIG  = 3,
    parameter int                     SCAN_DIV = 1,
    parameter int                     BLANK_LZ = 1,
    parameter logic [8*NUM_DIG-1:0]   LABEL    = {NUM_DIG{8'hFF}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      moneyv,
    input  logic                  blank,
    output logic [NUM_DIG-1:0]    sdpsel,
    output logic [7:0]            sdpdisp,
    output logic                  ovf,
    output logic                  upd
);

    localparam int NBCD  = nbcd(VAL_W);
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NIB_N = (NBCD > NUM_DIG) ? NBCD : NUM_DIG;

    logic [4*NBCD-1:0]    w_bcd;
    logic                 w_half;
    logic                 w_done;
    logic                 w_ovf_new;

    logic [4*NBCD-1:0]    r_dbcd;
    logic                 r_dhalf;
    logic                 r_ovf;
    logic                 r_upd;

    logic [PRE_W-1:0]     r_pre;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_DIG-1:0]   r_sel;
    logic [7:0]           r_disp;

    logic [4*NIB_N-1:0]   w_pad;
    logic [3:0]           w_cur_nib;
    logic                 w_upper_nz;
    logic [8*NUM_DIG-1:0] w_lab;
    logic [7:0]           w_pat;

    money_bin2bcd #(
        .VAL_W (VAL_W),
        .NBCD  (NBCD)
    ) u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_val  (moneyv),
        .o_bcd  (w_bcd),
        .o_half (w_half),
        .o_done (w_done)
    );

    always_comb begin
        w_ovf_new = 1'b0;
        for (int i = INT_DIG; i < NBCD; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_ovf_new = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbcd  <= '0;
            r_dhalf <= 1'b0;
            r_ovf   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= w_done;
            if (w_done) begin
                r_dbcd  <= w_bcd;
                r_dhalf <= w_half;
                r_ovf   <= w_ovf_new;
            end
        end
    end

    assign w_pad = (4*NIB_N)'(r_dbcd);

    // Leading-zero test covers the current nibble and every shown nibble above it.
    always_comb begin
        w_cur_nib  = 4'd0;
        w_upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIG; j++) begin
            if (j == int'(r_idx) - 1) begin
                w_cur_nib = w_pad[4*j +: 4];
            end
            if ((j >= int'(r_idx) - 1) && (j < INT_DIG) && (w_pad[4*j +: 4] != 4'd0)) begin
                w_upper_nz = 1'b1;
            end
        end
    end

    always_comb begin
        w_lab = LABEL >> {r_idx, 3'b000};
        w_pat = SEG_BLANK;
        if (r_idx == '0) begin
            if (r_ovf) begin
                w_pat = SEG_DASH;
            end else begin
                w_pat = r_dhalf ? SEG_DIGIT[5] : SEG_DIGIT[0];
            end
        end else if (int'(r_idx) <= INT_DIG) begin
            if (r_ovf) begin
                w_pat = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (r_idx != IDX_W'(1)) && !w_upper_nz) begin
                w_pat = SEG_BLANK;
            end else begin
                w_pat = seg_of(w_cur_nib);
            end
            if (r_idx == IDX_W'(1)) begin
                w_pat = w_pat & DP_MASK;
            end
        end else begin
            w_pat = w_lab[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_idx  <= '0;
            r_sel  <= '1;
            r_disp <= SEG_BLANK;
        end else begin
            if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == IDX_W'(NUM_DIG - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            r_sel  <= blank ? '1 : ~(NUM_DIG'(1) << r_idx);
            r_disp <= w_pat;
        end
    end

    assign sdpsel  = r_sel;
    assign sdpdisp = r_disp;
    assign ovf     = r_ovf;
    assign upd     = r_upd;

endmodule

// File: tb/tb_money_scan_disp.sv
// Directed bench: four display instances (default, no blanking, overflow with
// labels, slow scan) sharing clock, reset, money value and blank input.
module tb_money_scan_disp;

    localparam logic [63:0] LBL = 64'h86C788C6A1ABFFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            blank = 1'b0;
    logic [7:0]      moneyv = 8'd245;
    logic [3:0][7:0] sel_a;
    logic [3:0][7:0] disp_a;
    logic [3:0]      ovf_a;
    logic [3:0]      upd_a;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] cap [8];

    always #5 clk = ~clk;

    money_scan_disp u_def (
        .clk(clk), .rst_n(rst_n), .moneyv(moneyv), .blank(blank),
        .sdpsel(sel_a[0]), .sdpdisp(disp_a[0]), .ovf(ovf_a[0]), .upd(upd_a[0])
    );

    money_scan_disp #(.BLANK_LZ(0)) u_nlz (
        .clk(clk), .rst_n(rst_n), .moneyv(moneyv), .blank(blank),
        .sdpsel(sel_a[1]), .sdpdisp(disp_a[1]), .ovf(ovf_a[1]), .upd(upd_a[1])
    );

    money_scan_disp #(.INT_DIG(2), .LABEL(LBL)) u_ovf (
        .clk(clk), .rst_n(rst_n), .moneyv(moneyv), .blank(blank),
        .sdpsel(sel_a[2]), .sdpdisp(disp_a[2]), .ovf(ovf_a[2]), .upd(upd_a[2])
    );

    money_scan_disp #(.SCAN_DIV(4)) u_div (
        .clk(clk), .rst_n(rst_n), .moneyv(moneyv), .blank(blank),
        .sdpsel(sel_a[3]), .sdpdisp(disp_a[3]), .ovf(ovf_a[3]), .upd(upd_a[3])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame at SCAN_DIV=1: record the pattern shown at each selected position.
    task automatic capture(input int u);
        int bad;
        int nz;
        int pos;
        bad = 0;
        for (int k = 0; k < 8; k++) cap[k] = 8'h00;
        repeat (8) begin
            tick();
            nz  = 0;
            pos = 0;
            for (int k = 0; k < 8; k++) begin
                if (!sel_a[u][k]) begin
                    nz++;
                    pos = k;
                end
            end
            if (nz == 1) cap[pos] = disp_a[u];
            else bad++;
        end
        check($sformatf("onehot_u%0d", u), 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        int first_upd;
        int blank_bad;
        logic [7:0] d43;
        logic [7:0] def_sel [47];
        logic [7:0] div_sel [47];

        #12;
        check("rst_sel",  32'(sel_a[0]),  32'hFF);
        check("rst_disp", 32'(disp_a[0]), 32'hFF);
        check("rst_ovf",  32'(ovf_a[2]),  32'h0);
        check("rst_upd",  32'(upd_a[0]),  32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();

        capture(0);
        check("v245_p0", 32'(cap[0]), 32'h92);
        check("v245_p1", 32'(cap[1]), 32'h24);
        check("v245_p2", 32'(cap[2]), 32'hA4);
        check("v245_p3", 32'(cap[3]), 32'hF9);
        check("v245_p4", 32'(cap[4]), 32'hFF);
        check("v245_ovf", 32'(ovf_a[0]), 32'h0);

        capture(2);
        check("ovf_flag", 32'(ovf_a[2]), 32'h1);
        check("ovf_p0", 32'(cap[0]), 32'hBF);
        check("ovf_p1", 32'(cap[1]), 32'h3F);
        check("ovf_p2", 32'(cap[2]), 32'hBF);
        check("ovf_p3", 32'(cap[3]), 32'hA1);
        check("ovf_p7", 32'(cap[7]), 32'h86);

        n = 0;
        repeat (27) begin
            tick();
            if (upd_a[0]) n++;
        end
        check("upd_count", 32'(n), 32'd3);

        moneyv = 8'd7;
        repeat (20) tick();
        capture(0);
        check("v7_p0", 32'(cap[0]), 32'h92);
        check("v7_p1", 32'(cap[1]), 32'h30);
        check("v7_p2", 32'(cap[2]), 32'hFF);
        check("v7_p3", 32'(cap[3]), 32'hFF);
        capture(1);
        check("v7nlz_p1", 32'(cap[1]), 32'h30);
        check("v7nlz_p2", 32'(cap[2]), 32'hC0);
        check("v7nlz_p3", 32'(cap[3]), 32'hC0);
        capture(2);
        check("v7i2_ovf", 32'(ovf_a[2]), 32'h0);
        check("v7i2_p2",  32'(cap[2]),   32'hFF);

        moneyv = 8'd245;
        repeat (20) tick();
        check("pre_rst_ovf", 32'(ovf_a[2]), 32'h1);

        w = 0;
        while (!upd_a[0] && w < 20) begin
            tick();
            w++;
        end
        check("upd_seen", 32'(w < 20), 32'd1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel",  32'(sel_a[0]),  32'hFF);
        check("mid_rst_disp", 32'(disp_a[0]), 32'hFF);
        check("mid_rst_ovf",  32'(ovf_a[2]),  32'h0);
        check("mid_rst_dsel", 32'(sel_a[3]),  32'hFF);
        #3;
        @(negedge clk);
        rst_n = 1'b1;

        first_upd = 0;
        blank_bad = 0;
        d43 = 8'h00;
        for (int c = 1; c <= 46; c++) begin
            tick();
            if (upd_a[0] && first_upd == 0) first_upd = c;
            def_sel[c] = sel_a[0];
            div_sel[c] = sel_a[3];
            if (c >= 41 && c <= 45 && sel_a[0] != 8'hFF) blank_bad++;
            if (c == 43) d43 = disp_a[0];
            if (c == 40) blank = 1'b1;
            if (c == 45) blank = 1'b0;
        end
        check("first_upd", 32'(first_upd), 32'd10);
        check("restart_sel1", 32'(def_sel[1]), 32'hFE);
        check("restart_sel2", 32'(def_sel[2]), 32'hFD);
        check("div_c1",  32'(div_sel[1]),  32'hFE);
        check("div_c4",  32'(div_sel[4]),  32'hFE);
        check("div_c5",  32'(div_sel[5]),  32'hFD);
        check("div_c32", 32'(div_sel[32]), 32'h7F);
        check("div_c33", 32'(div_sel[33]), 32'hFE);
        check("blank_sel",  32'(blank_bad), 32'd0);
        check("blank_disp", 32'(d43), 32'hA4);
        check("blank_resume", 32'(def_sel[46]), 32'hDF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
